serial_deser_rx: RTL

//   Receiving end of the one-bit-per-clock serial line driven by our shift-register chain.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/serial_deser_rx_if.sv | 33 +++
 rtl/serial_shift_in.sv | 56 +++++
 rtl/serial_deser_rx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Definitions shared by the serial transmitter and the serial receiver:
//   FSM state encoding and the line levels of a frame.
//   Frame on the line: idle=0, start=1, data bits LSB first, [parity], stop=0.
//   Optional feature macro used by the receiver: PARITY_RX_EN.
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ser_state_t;

  localparam logic SER_IDLE_LVL  = 1'b0;
  localparam logic SER_START_LVL = 1'b1;
  localparam logic SER_STOP_LVL  = 1'b0;

endpackage

// File: rtl/serial_deser_rx_if.sv
// ---------------------------------------------------------------------------
// serial_deser_rx_if
//   Parallel side of the serial receiver: one-entry valid/ready word output
//   plus error/status flags.
//   Signals:
//     dout        received word, stable while dout_valid=1
//     dout_valid  dout holds an unconsumed word
//     dout_ready  consumer accepts dout when dout_valid & dout_ready
//     frame_err   1-cycle pulse, stop bit sampled as 1
//     parity_err  1-cycle pulse, parity mismatch
//     overrun     sticky, a good word was dropped because the buffer was full
//   Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface serial_deser_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport master (
    output dout, dout_valid, frame_err, parity_err, overrun,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_valid, frame_err, parity_err, overrun,
    output dout_ready
  );
endinterface

// File: rtl/serial_shift_in.sv
// ---------------------------------------------------------------------------
// serial_shift_in
//   DATA_W-bit right shift register: sin enters at the MSB, so after DATA_W
//   shifts the first (LSB-first) bit sits in data[0].
//   With PARITY_RX_EN defined it also keeps a running XOR of every bit taken
//   in (data bits while shifting, plus the parity bit via par_en).
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     sin        serial input bit
//     clear      restart for a new frame (start bit seen)
//     shift_en   shift sin into the register
//     data       assembled word
//     par_en     (PARITY_RX_EN) fold sin into parity without shifting
//     parity     (PARITY_RX_EN) running XOR, 0 means even parity holds
// ---------------------------------------------------------------------------
module serial_shift_in #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              clear,
  input  logic              shift_en,
  output logic [DATA_W-1:0] data
`ifdef PARITY_RX_EN
  ,
  input  logic              par_en,
  output logic              parity
`endif
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {sin, data[DATA_W-1:1]};
    end
  end

`ifdef PARITY_RX_EN
  // Running parity restarts with each frame so a previous frame's bits
  // never leak into the next check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity <= 1'b0;
    end else if (clear) begin
      parity <= 1'b0;
    end else if (shift_en || par_en) begin
      parity <= parity ^ sin;
    end
  end
`endif

endmodule

// File: rtl/serial_deser_rx.sv
// ---------------------------------------------------------------------------
// serial_deser_rx
//   Receiving end of the one-bit-per-clock serial line. Detects the start
//   bit, shifts in DATA_W data bits LSB first, checks the stop bit and
//   presents the word through a one-entry valid/ready buffer.
//   Optional feature macro: PARITY_RX_EN (one even-parity bit after data).
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous reset, active-low
//     sin   serial line, sampled once per clk
//     rx    serial_deser_rx_if.master: dout, dout_valid, dout_ready,
//           frame_err, parity_err, overrun
// ---------------------------------------------------------------------------
module serial_deser_rx
  import serial_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sin,
  serial_deser_rx_if.master   rx
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  ser_state_t        state;
  ser_state_t        state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              start;
  logic              shift_en;
  logic              stop_edge;
  logic              stop_bad;
  logic              par_bad;
  logic              good;
  logic [DATA_W-1:0] shift_data;

`ifdef PARITY_RX_EN
  logic              par_en;
  logic              parity_acc;
`endif

  serial_shift_in #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .sin      (sin),
    .clear    (start),
    .shift_en (shift_en),
    .data     (shift_data)
`ifdef PARITY_RX_EN
    ,
    .par_en   (par_en),
    .parity   (parity_acc)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // STOP always returns to IDLE; a start bit arriving during STOP is not
  // looked for, so the earliest next start is the cycle after STOP.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    stop_edge = 1'b0;
`ifdef PARITY_RX_EN
    par_en    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sin == SER_START_LVL) begin
          start     = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_RX_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef PARITY_RX_EN
      PARITY: begin
        par_en    = 1'b1;
        state_nxt = STOP;
      end
`endif
      STOP: begin
        stop_edge = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counts data bits; sits at 0 outside DATA so each frame starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (state == DATA && bit_cnt != LAST_BIT) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end else begin
      bit_cnt <= '0;
    end
  end

  assign stop_bad = stop_edge && (sin != SER_STOP_LVL);
`ifdef PARITY_RX_EN
  assign par_bad  = stop_edge && parity_acc;
`else
  assign par_bad  = 1'b0;
`endif
  assign good     = stop_edge && !stop_bad && !par_bad;

  // Output buffer: a good word loads if the slot is free or being consumed
  // on this same edge; otherwise it is dropped and overrun latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx.dout       <= '0;
      rx.dout_valid <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.frame_err  <= stop_bad;
      rx.parity_err <= par_bad;
      if (good && (!rx.dout_valid || rx.dout_ready)) begin
        rx.dout       <= shift_data;
        rx.dout_valid <= 1'b1;
      end else if (rx.dout_valid && rx.dout_ready) begin
        rx.dout_valid <= 1'b0;
      end
      if (good && rx.dout_valid && !rx.dout_ready) begin
        rx.overrun <= 1'b1;
      end
    end
  end

endmodule
